// File: rtl/adc_frontend_pkg.sv
// adc_frontend_pkg
// Shared constants and sample-format helpers for the ADC front end.
//   DEF_DATA_W : default sample width (the DDC input width)
//   SAT_MAX    : largest two's-complement sample (+2047 at 12 bits)
//   SAT_MIN    : smallest two's-complement sample (-2048 at 12 bits)
//   ob_to_tc   : offset binary -> two's complement (invert the MSB)
//   sat_sub    : a - b in one extra bit, clamped to [SAT_MIN, SAT_MAX]
// The helpers are sized to DEF_DATA_W, so the top-level DATA_W has to match it.
package adc_frontend_pkg;

  localparam int DEF_DATA_W = 12;

  localparam logic [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
  localparam logic [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

  function automatic logic [DEF_DATA_W-1:0] ob_to_tc(input logic [DEF_DATA_W-1:0] raw);
    return {~raw[DEF_DATA_W-1], raw[DEF_DATA_W-2:0]};
  endfunction

  // The operands are sign-extended by one bit. If the top two bits of the
  // difference disagree, the result left the representable range, and the
  // sign bit shows which way it went.
  function automatic logic [DEF_DATA_W-1:0] sat_sub(input logic [DEF_DATA_W-1:0] a,
                                                    input logic [DEF_DATA_W-1:0] b);
    logic [DEF_DATA_W:0] diff;
    diff = {a[DEF_DATA_W-1], a} - {b[DEF_DATA_W-1], b};
    if (diff[DEF_DATA_W] != diff[DEF_DATA_W-1])
      return diff[DEF_DATA_W] ? SAT_MIN : SAT_MAX;
    return diff[DEF_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/adc_frontend_prf.sv
// prf_sync
// Brings the asynchronous PRF trigger into the Clk_160 domain and qualifies it.
// A rising edge is accepted only when the hold-off counter has reached zero.
//   Clk_160    : sample clock
//   Rst        : synchronous, active-high reset
//   Trig_async : asynchronous trigger level, active-high
//   accept     : one-cycle strobe (combinational from flops) for an accepted rise
module prf_sync
  import adc_frontend_pkg::*;
#(
  parameter int HOLDOFF = 16
) (
  input  logic Clk_160,
  input  logic Rst,
  input  logic Trig_async,
  output logic accept
);

  localparam int HW = $clog2(HOLDOFF);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

  logic ff1_q, ff1_d;
  logic ff2_q, ff2_d;
  logic ff3_q, ff3_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic rise;

  // ff1/ff2 resolve metastability. ff3 holds the previous value of ff2 for edge
  // detection, so a level held high gives a single rise.
  always_comb begin
    ff1_d  = Trig_async;
    ff2_d  = ff1_q;
    ff3_d  = ff2_q;
    rise   = ff2_q & ~ff3_q;
    accept = rise && (holdoff_q == '0);
    if (accept)
      holdoff_d = HOLD_LOAD;
    else if (holdoff_q != '0)
      holdoff_d = holdoff_q - 1'b1;
    else
      holdoff_d = holdoff_q;
  end

  always_ff @(posedge Clk_160) begin
    if (Rst) begin
      ff1_q     <= 1'b0;
      ff2_q     <= 1'b0;
      ff3_q     <= 1'b0;
      holdoff_q <= '0;
    end else begin
      ff1_q     <= ff1_d;
      ff2_q     <= ff2_d;
      ff3_q     <= ff3_d;
      holdoff_q <= holdoff_d;
    end
  end

endmodule

// File: rtl/adc_frontend.sv
// adc_frontend
// Conditioning stage in front of the DDC. It converts offset-binary ADC samples
// to two's complement, removes a block-averaged DC estimate with saturation,
// qualifies the PRF trigger and tracks overrange per PRF interval.
//   Clk_160    : sample clock
//   Rst        : synchronous, active-high reset
//   Adc_data   : raw ADC sample, offset binary
//   Adc_ovr    : ADC overrange flag, aligned with Adc_data
//   Trig_async : asynchronous PRF trigger level
//   Dc_en      : 1 = subtract the DC estimate, 0 = pass through
//   Data_out   : corrected sample, two's complement, 2-cycle latency
//   Prf_out    : one-cycle accepted PRF pulse
//   Dc_offset  : current DC estimate, two's complement
//   Ovr_count  : overrange samples since the last accepted PRF, saturating
//   Ovr_flag   : any overrange since the last accepted PRF
module adc_frontend
  import adc_frontend_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AVG_LOG2 = 10,
  parameter int HOLDOFF  = 16
) (
  input  logic              Clk_160,
  input  logic              Rst,
  input  logic [DATA_W-1:0] Adc_data,
  input  logic              Adc_ovr,
  input  logic              Trig_async,
  input  logic              Dc_en,
  output logic [DATA_W-1:0] Data_out,
  output logic              Prf_out,
  output logic [DATA_W-1:0] Dc_offset,
  output logic [15:0]       Ovr_count,
  output logic              Ovr_flag
);

  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [DATA_W-1:0]   adc_data_q, adc_data_d;
  logic                adc_ovr_q, adc_ovr_d;
  logic                smp_vld_q, smp_vld_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   dc_offset_q, dc_offset_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                prf_q, prf_d;
  logic [15:0]         ovr_count_q, ovr_count_d;
  logic                ovr_flag_q, ovr_flag_d;

  logic [DATA_W-1:0] x;
  logic [ACC_W-1:0]  x_ext;
  logic [ACC_W-1:0]  acc_sum;
  logic              accept;

  prf_sync #(
    .HOLDOFF (HOLDOFF)
  ) u_prf_sync (
    .Clk_160    (Clk_160),
    .Rst        (Rst),
    .Trig_async (Trig_async),
    .accept     (accept)
  );

  // smp_vld keeps the reset value of the stage-1 register out of the average.
  // The first block therefore covers the first 2^AVG_LOG2 real samples and
  // finishes on edge 2^AVG_LOG2 + 1 after reset. Taking the top DATA_W bits of
  // the block sum is the arithmetic right shift by AVG_LOG2 (floor).
  always_comb begin
    adc_data_d = Adc_data;
    adc_ovr_d  = Adc_ovr;
    smp_vld_d  = 1'b1;

    x       = ob_to_tc(adc_data_q);
    x_ext   = {{AVG_LOG2{x[DATA_W-1]}}, x};
    acc_sum = acc_q + x_ext;

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dc_offset_d = dc_offset_q;
    if (smp_vld_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        acc_d       = '0;
        dc_offset_d = acc_sum[ACC_W-1:AVG_LOG2];
      end else begin
        acc_d = acc_sum;
      end
    end

    data_out_d = sat_sub(x, Dc_en ? dc_offset_q : '0);
    prf_d      = accept;

    // When an accept coincides with an overrange sample, that sample is counted
    // in the new interval.
    ovr_count_d = ovr_count_q;
    ovr_flag_d  = ovr_flag_q;
    if (accept) begin
      ovr_count_d = {15'd0, adc_ovr_q};
      ovr_flag_d  = adc_ovr_q;
    end else if (adc_ovr_q) begin
      ovr_flag_d = 1'b1;
      if (ovr_count_q != 16'hFFFF)
        ovr_count_d = ovr_count_q + 16'd1;
    end
  end

  always_ff @(posedge Clk_160) begin
    if (Rst) begin
      adc_data_q  <= '0;
      adc_ovr_q   <= 1'b0;
      smp_vld_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      dc_offset_q <= '0;
      data_out_q  <= '0;
      prf_q       <= 1'b0;
      ovr_count_q <= '0;
      ovr_flag_q  <= 1'b0;
    end else begin
      adc_data_q  <= adc_data_d;
      adc_ovr_q   <= adc_ovr_d;
      smp_vld_q   <= smp_vld_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dc_offset_q <= dc_offset_d;
      data_out_q  <= data_out_d;
      prf_q       <= prf_d;
      ovr_count_q <= ovr_count_d;
      ovr_flag_q  <= ovr_flag_d;
    end
  end

  assign Data_out  = data_out_q;
  assign Prf_out   = prf_q;
  assign Dc_offset = dc_offset_q;
  assign Ovr_count = ovr_count_q;
  assign Ovr_flag  = ovr_flag_q;

endmodule

// File: tb/tb_adc_frontend.sv
// tb_adc_frontend
// Directed bench for adc_frontend, built with AVG_LOG2 = 4 and HOLDOFF = 16.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, which is half a cycle away from the active rising edge.
module tb_adc_frontend;

  logic        Clk_160;
  logic        Rst;
  logic [11:0] Adc_data;
  logic        Adc_ovr;
  logic        Trig_async;
  logic        Dc_en;
  logic [11:0] Data_out;
  logic        Prf_out;
  logic [11:0] Dc_offset;
  logic [15:0] Ovr_count;
  logic        Ovr_flag;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [11:0] adc;
    logic        dc_en;
    logic [11:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  adc_frontend #(
    .DATA_W   (12),
    .AVG_LOG2 (4),
    .HOLDOFF  (16)
  ) dut (
    .Clk_160    (Clk_160),
    .Rst        (Rst),
    .Adc_data   (Adc_data),
    .Adc_ovr    (Adc_ovr),
    .Trig_async (Trig_async),
    .Dc_en      (Dc_en),
    .Data_out   (Data_out),
    .Prf_out    (Prf_out),
    .Dc_offset  (Dc_offset),
    .Ovr_count  (Ovr_count),
    .Ovr_flag   (Ovr_flag)
  );

  initial Clk_160 = 1'b0;
  always #5 Clk_160 = ~Clk_160;

  task automatic tick();
    @(posedge Clk_160);
    @(negedge Clk_160);
  endtask

  task automatic applyStimulus(input logic [11:0] adc, input logic ovr,
                               input logic trig, input logic dc_en);
    Adc_data   = adc;
    Adc_ovr    = ovr;
    Trig_async = trig;
    Dc_en      = dc_en;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Rst is released on a falling edge, so the next rising edge is edge 1.
  task automatic resetDut();
    Rst = 1'b1;
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    Rst = 1'b0;
  endtask

  // Trigger rises at c = 2 (and at 2 + gap when gap > 0), each high for len cycles.
  task automatic runTrig(input int gap, input int len, output int pulses,
                         output int first_at, output int last_at);
    resetDut();
    pulses   = 0;
    first_at = -1;
    last_at  = -1;
    for (int c = 0; c < 2 + gap + len + 24; c++) begin
      logic t;
      t = (c >= 2 && c < 2 + len) || (gap > 0 && c >= 2 + gap && c < 2 + gap + len);
      applyStimulus(12'h800, 1'b0, t, 1'b0);
      tick();
      if (Prf_out === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = c;
        last_at = c;
      end
    end
  endtask

  initial begin
    int pulses, first_at, last_at;

    vecs[0] = '{12'h000, 1'b0, 12'h800};
    vecs[1] = '{12'h800, 1'b0, 12'h000};
    vecs[2] = '{12'hFFF, 1'b0, 12'h7FF};
    vecs[3] = '{12'h900, 1'b1, 12'h100};
    vecs[4] = '{12'h7FF, 1'b0, 12'hFFF};
    vecs[5] = '{12'h123, 1'b1, 12'h923};
    vecs[6] = '{12'hABC, 1'b0, 12'h2BC};
    vecs[7] = '{12'h001, 1'b1, 12'h801};

    // Reset holds every output at zero while inputs are busy.
    Rst = 1'b1;
    applyStimulus(12'hABC, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(12'hABC, 1'b1, 1'(i % 2), 1'b1);
      tick();
      checkOutput($sformatf("reset_outs%0d", i),
                  {Data_out, Prf_out, Dc_offset, Ovr_count, Ovr_flag}, 64'd0);
    end
    Rst = 1'b0;

    // Format conversion. All vectors fall inside the first block, where the
    // estimate is still zero, so Dc_en does not change the result.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) applyStimulus(vecs[i].adc, 1'b0, 1'b0, vecs[i].dc_en);
      tick();
      if (i >= 1) checkOutput($sformatf("vec%0d", i - 1), Data_out, vecs[i-1].exp_data);
    end
    checkOutput("vec_dc_zero", Dc_offset, 12'h000);

    // DC removal: 0x900 -> +256 passes through, then the estimate becomes 256.
    resetDut();
    applyStimulus(12'h900, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    checkOutput("dc_passthru", Data_out, 12'h100);
    repeat (14) tick();
    checkOutput("dc_before_update", Dc_offset, 12'h000);
    tick();
    checkOutput("dc_offset_256", Dc_offset, 12'h100);
    checkOutput("dc_en0_keeps", Data_out, 12'h100);
    applyStimulus(12'h900, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    checkOutput("dc_removed", Data_out, 12'h000);

    // Positive saturation with estimate -256. The update lands on the following sample.
    resetDut();
    applyStimulus(12'h700, 1'b0, 1'b0, 1'b1);
    repeat (17) tick();
    checkOutput("dc_offset_m256", Dc_offset, 12'hF00);
    checkOutput("update_old_offset", Data_out, 12'hF00);
    applyStimulus(12'hFFF, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("update_new_offset", Data_out, 12'h000);
    tick();
    checkOutput("sat_high", Data_out, 12'h7FF);
    applyStimulus(12'h600, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    checkOutput("sub_in_range_neg", Data_out, 12'hF00);

    // Negative saturation with estimate +256.
    resetDut();
    applyStimulus(12'h900, 1'b0, 1'b0, 1'b1);
    repeat (17) tick();
    checkOutput("dc_offset_p256", Dc_offset, 12'h100);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    checkOutput("sat_low", Data_out, 12'h800);
    applyStimulus(12'h001, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    checkOutput("sat_low_m2047", Data_out, 12'h800);
    applyStimulus(12'h7FF, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    checkOutput("sub_m257", Data_out, 12'hEFF);

    // Hold-off behaviour.
    runTrig(10, 3, pulses, first_at, last_at);
    checkOutput("holdoff_gap10_pulses", pulses, 1);
    checkOutput("prf_latency", first_at, 4);
    runTrig(15, 3, pulses, first_at, last_at);
    checkOutput("holdoff_gap15_pulses", pulses, 1);
    runTrig(16, 3, pulses, first_at, last_at);
    checkOutput("holdoff_gap16_pulses", pulses, 2);
    checkOutput("holdoff_gap16_second", last_at, 20);
    runTrig(0, 100, pulses, first_at, last_at);
    checkOutput("held_high_pulses", pulses, 1);

    // Overrange counting and restart on accept.
    resetDut();
    applyStimulus(12'h800, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ovr_idle", {Ovr_count, Ovr_flag}, {16'd0, 1'b0});
    repeat (5) begin
      applyStimulus(12'h800, 1'b1, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(12'h800, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    checkOutput("ovr_count5", Ovr_count, 16'd5);
    checkOutput("ovr_flag_set", Ovr_flag, 1'b1);
    applyStimulus(12'h800, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(12'h800, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(12'h800, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("ovr_accept_prf", Prf_out, 1'b1);
    checkOutput("ovr_accept_count1", Ovr_count, 16'd1);
    checkOutput("ovr_accept_flag", Ovr_flag, 1'b1);
    tick();
    checkOutput("ovr_after_accept", {Prf_out, Ovr_count}, {1'b0, 16'd1});
    applyStimulus(12'h800, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    repeat (2) begin
      applyStimulus(12'h800, 1'b1, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(12'h800, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    checkOutput("ovr_count3", Ovr_count, 16'd3);
    applyStimulus(12'h800, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("ovr_clear_prf", Prf_out, 1'b1);
    checkOutput("ovr_clear", {Ovr_count, Ovr_flag}, {16'd0, 1'b0});

    // Overrange count saturation.
    resetDut();
    applyStimulus(12'h800, 1'b1, 1'b0, 1'b0);
    repeat (70000) tick();
    checkOutput("ovr_sat", Ovr_count, 16'hFFFF);
    checkOutput("ovr_sat_flag", Ovr_flag, 1'b1);

    // Reset in the middle of a block and during hold-off.
    resetDut();
    applyStimulus(12'h900, 1'b0, 1'b0, 1'b0);
    repeat (17) tick();
    checkOutput("mid_dc_first", Dc_offset, 12'h100);
    applyStimulus(12'h900, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("mid_prf_first", Prf_out, 1'b1);
    applyStimulus(12'h900, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    Rst = 1'b1;
    tick(); tick();
    checkOutput("mid_rst_dc", Dc_offset, 12'h000);
    checkOutput("mid_rst_prf", Prf_out, 1'b0);
    Rst = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      applyStimulus(12'hA00, 1'b0, 1'(e >= 4), 1'b0);
      tick();
      if (e == 6)  checkOutput("mid_trig_accepted", Prf_out, 1'b1);
      if (e == 16) checkOutput("mid_dc_pending", Dc_offset, 12'h000);
      if (e == 17) checkOutput("mid_dc_new_block", Dc_offset, 12'h200);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_frontend.md
# adc_frontend

ADC front-end conditioning stage directly upstream of the DDC, running in the 160 MHz sample domain. It converts raw offset-binary ADC samples to two's complement and removes a block-averaged DC offset with saturation. It also synchronises the asynchronous PRF trigger into a single-cycle, hold-off-qualified pulse, and tracks ADC overrange per PRF interval. Data_out feeds the DDC's 12-bit sample input; Prf_out feeds the DDC's PRF input.

## Interface
- DATA_W, 12: sample width.
- AVG_LOG2, 10: log2 of the DC-estimate block length (2^AVG_LOG2 samples).
- HOLDOFF, 16: minimum Clk_160 cycles between accepted PRF pulses (≥2).

- Clk_160  in  1  sample clock; all logic in this domain.
- Rst  in  1  reset, synchronous, active-high; clock Clk_160.
- Adc_data  in  DATA_W  raw ADC sample, offset binary.
- Adc_ovr  in  1  ADC overrange flag, same cycle as Adc_data.
- Trig_async  in  1  asynchronous PRF trigger, level, active-high.
- Dc_en  in  1  1 = subtract DC estimate, 0 = pass through.
- Data_out  out  DATA_W  corrected sample, two's complement.
- Prf_out  out  1  single-cycle accepted PRF pulse.
- Dc_offset  out  DATA_W  current DC estimate, two's complement.
- Ovr_count  out  16  overrange samples since last accepted PRF, saturating.
- Ovr_flag  out  1  sticky: any overrange since last accepted PRF.

## Operation
- All outputs reset to 0. Rst clears the accumulator, sample counter, synchroniser, hold-off counter and overrange state.
- **Stage 1:** register Adc_data and Adc_ovr.
  - x = Adc_data_reg with MSB inverted (0x000 → -2048, 0x800 → 0, 0xFFF → 2047).
- **DC estimator:**
  - Signed accumulator, DATA_W+AVG_LOG2 bits, plus a sample counter of AVG_LOG2 bits.
  - Every cycle: acc += x (uncorrected sample).
  - When counter = all-ones (wrap): Dc_offset <= (acc + x) >>> AVG_LOG2 (arithmetic shift, floor), and acc <= 0.
  - Counter wraps freely; no overflow is possible.
- **Stage 2:** y = x − Dc_offset if Dc_en else x.
  - Computed in DATA_W+1 bits, saturated to [-2048, 2047], registered to Data_out.
  - A Dc_offset update takes effect on the following sample.
  - Dc_en is sampled in the same cycle as x.
- **Trigger path:**
  - ff1 → ff2 → ff3 chain; rise = ff2 & ~ff3.
  - If rise and holdoff_cnt = 0: accept. Prf_out <= 1 for one cycle and holdoff_cnt <= HOLDOFF−1.
  - holdoff_cnt otherwise decrements to 0 and holds.
  - A rise while holdoff_cnt ≠ 0 is dropped silently.
  - A level held high produces exactly one pulse.
- **Overrange:**
  - Ovr_count increments on Adc_ovr_reg, saturating at 0xFFFF.
  - Ovr_flag sets on Adc_ovr_reg.
  - On accept, both restart: Ovr_count <= Adc_ovr_reg ? 1 : 0, and Ovr_flag <= Adc_ovr_reg.
  - An overrange in the same cycle as an accept is therefore counted in the new interval.

## Timing
- Adc_data → Data_out: 2 cycles; throughput one sample per cycle, no stalls.
- Trig_async high at edge k (meeting setup) → Prf_out high for the cycle following edge k+2. Asynchronous uncertainty: +1 cycle.
- Accepted pulses are at least HOLDOFF cycles apart; a rise exactly HOLDOFF cycles after the previous accept is accepted.
- First Dc_offset update: edge 2^AVG_LOG2 + 1 after Rst deasserts.
- Rst asserted mid-block: the partial sum is discarded and Dc_offset returns to 0. Estimation restarts from counter 0.
- Rst during hold-off: holdoff_cnt cleared; the synchroniser needs 3 clean cycles before the next accept.

## Structure
- Package adc_frontend_pkg:
  - DATA_W default.
  - SAT_MAX/SAT_MIN constants.
  - Saturating subtract function.
  - Offset-binary-to-two's-complement function.
- Sub-module prf_sync: 3-FF synchroniser, edge detect, hold-off counter; outputs the accept strobe.
- Top level holds the data path, DC estimator and overrange logic.

## Test plan
- **Reset:** Rst for 5 cycles with Adc_data = 0xABC and Trig_async toggling → all outputs 0 throughout; no Prf_out.
- **DC removal** (AVG_LOG2 = 4): constant Adc_data = 0x900, Dc_en = 0 → Data_out = 256 two cycles later. After 16 samples Dc_offset = 256. Set Dc_en = 1 → Data_out = 0.
- **Saturation:**
  - Fill a block with 0x700 so Dc_offset = −256, then Adc_data = 0xFFF with Dc_en = 1 → Data_out = 2047 (not wrapped).
  - Symmetric case: Dc_offset = +256, Adc_data = 0x000 → −2048.
- **Hold-off** (HOLDOFF = 16):
  - Trig rises 10 cycles apart → one Prf_out.
  - Rises 16 cycles apart → two Prf_out.
  - Trigger held high 100 cycles → one Prf_out.
- **Overrange:**
  - 5 Adc_ovr cycles → Ovr_count = 5, Ovr_flag = 1.
  - Accept coinciding with Adc_ovr → Ovr_count = 1.
  - 70000 overrange cycles → Ovr_count = 0xFFFF.
- **Reset mid-operation:** Rst at counter = 7 of a block and during hold-off → Dc_offset = 0; the next block completes 16 samples after release; a trigger 3 cycles after release is accepted.
